tx_word_serializer: RTL and testbench
=====================================

// Module: tx_word_serializer
// PURPOSE
//  Parametrised successor to the byte-wide transmit FSM. Pops one WORD_BYTES-wide word from the
//  read-side FIFO and serialises it byte-by-byte into the UART transmitter, one byte per tx_done.
//  Sits between the DDR3 read-data FIFO and the UART TX. Adds multi-byte words, selectable byte
//  order, programmable FIFO read latency, a word-complete strobe and a busy flag.
// PARAMETERS
//  WORD_BYTES   4  bytes per FIFO word (>=1); fifo_data is 8*WORD_BYTES bits
//  MSB_FIRST    0  0: byte 0 (bits [7:0]) sent first; 1: top byte sent first
//  FIFO_RD_LAT  1  cycles from o_rden_fifo high to fifo_data valid (>=1)
// PORTS
//  clk          in   1              single clock; all logic on rising edge
//  rst          in   1              one clock; reset is asynchronous and active-high
//  fifo_empty   in   1              FIFO has no word available
//  fifo_data    in   8*WORD_BYTES   FIFO read data, valid FIFO_RD_LAT cycles after o_rden_fifo
//  tx_done      in   1              UART finished current byte (1-cycle pulse)
//  o_rden_fifo  out  1              FIFO read enable, exactly 1 cycle per word
//  o_tx_data    out  8              byte to transmit
//  tx_valid     out  1              1-cycle start pulse to UART TX
//  o_busy       out  1              high from o_rden_fifo until word_done inclusive
//  o_word_done  out  1              1-cycle pulse after last byte's tx_done
//  o_byte_idx   out  max(1,clog2(WORD_BYTES))  index of byte on o_tx_data (transmit order)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, shift reg/counters 0; rst asserted mid-word abandons the
//   word (no tx_valid/word_done afterwards, no retry); popped word is lost.
//  All outputs registered (Moore). States: IDLE, READ, WAIT_DATA, SEND, WAIT_DONE, DONE.
//  IDLE: if !fifo_empty -> READ. fifo_empty sampled only in IDLE.
//  READ: o_rden_fifo=1 for this cycle only; -> WAIT_DATA with latency counter = FIFO_RD_LAT-1.
//  WAIT_DATA: on counter==0 capture fifo_data into shift reg, byte_idx=0, -> SEND; else decrement.
//  SEND: tx_valid=1 one cycle; o_tx_data = byte selected by MSB_FIRST/byte_idx; -> WAIT_DONE.
//  WAIT_DONE: hold o_tx_data stable; on tx_done: if byte_idx==WORD_BYTES-1 -> DONE, else
//   byte_idx+1 -> SEND. tx_done in any other state is ignored.
//  DONE: o_word_done=1 one cycle -> IDLE. Next pop earliest one cycle later (no back-to-back).
//  Latency: fifo_empty low in IDLE at cycle N -> o_rden_fifo at N+1 -> capture at N+1+FIFO_RD_LAT
//   -> first tx_valid at N+2+FIFO_RD_LAT. tx_done at M -> next tx_valid at M+2.
//  tx_done in same cycle as tx_valid is ignored (UART cannot finish a byte it has not started).
//  WORD_BYTES=1: degenerates to byte-wide FSM; byte_idx constant 0.
//  o_busy low only in IDLE. Byte index never exceeds WORD_BYTES-1; no wrap.
//  fifo_data ignored except on capture cycle; changes elsewhere do not affect o_tx_data.
// TESTING
//  1 WORD_BYTES=4,MSB_FIRST=0, word 32'hA1B2C3D4, tx_done 10 cyc after each tx_valid
//    -> bytes D4,C3,B2,A1; 4 tx_valid pulses; 1 rden; word_done once after 4th tx_done.
//  2 Same word, MSB_FIRST=1 -> A1,B2,C3,D4; byte_idx 0,1,2,3.
//  3 FIFO_RD_LAT=3, fifo_empty falls cycle 5 -> rden cycle 6, first tx_valid cycle 10;
//    fifo_data garbage before cycle 9 never appears on o_tx_data.
//  4 Two words queued (fifo_empty stays low) -> exactly 2 rden pulses, second 1 cycle after
//    first word_done; 8 bytes in order; spurious tx_done while IDLE/SEND ignored.
//  5 rst pulsed while in WAIT_DONE of byte 2 -> all outputs 0 within same cycle (async); with
//    fifo_empty=1 afterwards, no further tx_valid/word_done.
//  6 WORD_BYTES=1, bytes 8'h55,8'hAA -> two single-byte words, word_done after each tx_done.

Source files
------------

// File: rtl/tx_word_serializer.sv
// Transmit serializer: pops one WORD_BYTES-wide word from the read-data FIFO and hands it
// to the UART transmitter one byte at a time, in either byte order.
module tx_word_serializer #(
  parameter int WORD_BYTES  = 4,
  parameter bit MSB_FIRST   = 1'b0,
  parameter int FIFO_RD_LAT = 1,
  localparam int IDX_W      = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fifo_empty,
  input  logic [8*WORD_BYTES-1:0] fifo_data,
  input  logic                    tx_done,
  output logic                    o_rden_fifo,
  output logic [7:0]              o_tx_data,
  output logic                    tx_valid,
  output logic                    o_busy,
  output logic                    o_word_done,
  output logic [IDX_W-1:0]        o_byte_idx
);

  localparam int W     = 8 * WORD_BYTES;
  localparam int CNT_W = (FIFO_RD_LAT > 1) ? $clog2(FIFO_RD_LAT) : 1;

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(FIFO_RD_LAT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT_DATA,
    S_SEND,
    S_WAIT_DONE,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [W-1:0]     shift_q;
  logic [CNT_W-1:0] lat_cnt_q;
  logic [IDX_W-1:0] byte_idx_q;
  logic             tx_done_q;
  logic             rden_q;
  logic             tx_valid_q;
  logic             busy_q;
  logic             word_done_q;
  logic [7:0]       tx_data_q;

  logic [W-1:0]     src_word_d;
  logic [W-1:0]     shift_d;
  logic [7:0]       send_byte_d;

  // The byte to send next always sits at the "head" end of the shift register.
  function automatic logic [7:0] head_byte(input logic [W-1:0] w);
    head_byte = MSB_FIRST ? w[W-1 -: 8] : w[7:0];
  endfunction

  function automatic logic [W-1:0] advance(input logic [W-1:0] w);
    advance = MSB_FIRST ? (w << 8) : (w >> 8);
  endfunction

  // NOTE: every output of a combinational block is assigned on every path, so no latch can form.
  always_comb begin
    src_word_d  = (state_q == S_WAIT_DATA) ? fifo_data : shift_q;
    send_byte_d = head_byte(src_word_d);
    shift_d     = advance(src_word_d);
  end

  // tx_done is registered and only accepted while a byte is in flight, so a pulse
  // coinciding with tx_valid (or arriving in any other state) can never advance the word.
  // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      lat_cnt_q   <= '0;
      byte_idx_q  <= '0;
      tx_done_q   <= 1'b0;
      rden_q      <= 1'b0;
      tx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      word_done_q <= 1'b0;
      tx_data_q   <= '0;
    end else begin
      rden_q      <= 1'b0;
      tx_valid_q  <= 1'b0;
      word_done_q <= 1'b0;
      tx_done_q   <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            state_q <= S_READ;
            rden_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end

        S_READ: begin
          state_q   <= S_WAIT_DATA;
          lat_cnt_q <= LAT_LOAD;
        end

        S_WAIT_DATA: begin
          if (lat_cnt_q == '0) begin
            shift_q    <= shift_d;
            tx_data_q  <= send_byte_d;
            byte_idx_q <= '0;
            tx_valid_q <= 1'b1;
            state_q    <= S_SEND;
          end else begin
            lat_cnt_q <= lat_cnt_q - 1'b1;
          end
        end

        S_SEND: begin
          state_q <= S_WAIT_DONE;
        end

        S_WAIT_DONE: begin
          tx_done_q <= tx_done & ~tx_done_q;
          if (tx_done_q) begin
            if (byte_idx_q == LAST_IDX) begin
              word_done_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              shift_q    <= shift_d;
              tx_data_q  <= send_byte_d;
              byte_idx_q <= byte_idx_q + 1'b1;
              tx_valid_q <= 1'b1;
              state_q    <= S_SEND;
            end
          end
        end

        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_rden_fifo = rden_q;
  assign o_tx_data   = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign o_busy      = busy_q;
  assign o_word_done = word_done_q;
  assign o_byte_idx  = byte_idx_q;

endmodule

// File: tb/tb_tx_word_serializer.sv
// Scoreboard bench: two 4-byte serializers (MSB-first and LSB-first, read latency 3) share
// a FIFO/UART model; a byte-wide instance gets a short directed run.
`timescale 1ns/1ps
module tb_tx_word_serializer;

  localparam int WB  = 4;
  localparam int LAT = 3;
  localparam int NW  = 24;

  typedef struct {
    logic [7:0] data;
    int         idx;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst;
  logic        fifo_empty;
  logic [31:0] fifo_data;
  logic        tx_done;

  logic       a_rden, a_txv, a_busy, a_wd;
  logic [7:0] a_data;
  logic [1:0] a_idx;
  logic       b_rden, b_txv, b_busy, b_wd;
  logic [7:0] b_data;
  logic [1:0] b_idx;

  logic       c_empty, c_tx_done;
  logic [7:0] c_fdata;
  logic       c_rden, c_txv, c_busy, c_wd;
  logic [7:0] c_data;
  logic [0:0] c_idx;

  tx_word_serializer #(.WORD_BYTES(WB), .MSB_FIRST(1'b1), .FIFO_RD_LAT(LAT)) dut_a (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data), .tx_done(tx_done),
    .o_rden_fifo(a_rden), .o_tx_data(a_data), .tx_valid(a_txv), .o_busy(a_busy),
    .o_word_done(a_wd), .o_byte_idx(a_idx)
  );

  tx_word_serializer #(.WORD_BYTES(WB), .MSB_FIRST(1'b0), .FIFO_RD_LAT(LAT)) dut_b (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data), .tx_done(tx_done),
    .o_rden_fifo(b_rden), .o_tx_data(b_data), .tx_valid(b_txv), .o_busy(b_busy),
    .o_word_done(b_wd), .o_byte_idx(b_idx)
  );

  tx_word_serializer #(.WORD_BYTES(1), .MSB_FIRST(1'b0), .FIFO_RD_LAT(1)) dut_c (
    .clk(clk), .rst(rst), .fifo_empty(c_empty), .fifo_data(c_fdata), .tx_done(c_tx_done),
    .o_rden_fifo(c_rden), .o_tx_data(c_data), .tx_valid(c_txv), .o_busy(c_busy),
    .o_word_done(c_wd), .o_byte_idx(c_idx)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int k);
    return 8'(w >> (8 * k));
  endfunction

  // Shared state: main sequence controls, FIFO model, scoreboards, model bookkeeping
  bit          model_on   = 1'b0;
  bit          spur_en    = 1'b0;
  int          gen_target = 0;
  int          uart_delay = 0;
  int          pushed     = 0;
  logic [31:0] fifo_q[$];
  exp_t        exp_a[$];
  exp_t        exp_b[$];
  logic [7:0]  exp_c[$];
  int          done_at    = -1;
  int          n_rden = 0, n_txv = 0, n_wd = 0;

  task automatic push_word(input logic [31:0] w);
    exp_t e;
    fifo_q.push_back(w);
    for (int i = 0; i < WB; i++) begin
      e.idx  = i;
      e.data = byte_of(w, WB - 1 - i);
      exp_a.push_back(e);
      e.data = byte_of(w, i);
      exp_b.push_back(e);
    end
    pushed++;
  endtask

  // Driver: FIFO with LAT-cycle read data (garbage otherwise), word generator, UART model
  initial begin : driver
    logic [31:0] pend;
    int rd_cnt;
    rd_cnt     = -1;
    pend       = '0;
    fifo_empty = 1'b1;
    fifo_data  = '0;
    tx_done    = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        rd_cnt = -1;
        fifo_q.delete();
        fifo_empty = 1'b1;
        fifo_data  = $urandom;
        tx_done    = 1'b0;
        continue;
      end
      if (rd_cnt > 0) rd_cnt--;
      else if (rd_cnt == 0) rd_cnt = -1;
      if (a_rden && fifo_q.size() > 0) begin
        pend   = fifo_q.pop_front();
        rd_cnt = LAT;
      end
      fifo_data = (rd_cnt == 0) ? pend : $urandom;

      if (pushed == 0 && gen_target >= 2) begin
        push_word(32'hA1B2C3D4);
        push_word($urandom);
      end else if (pushed < gen_target && $urandom_range(0, 5) == 0) begin
        push_word($urandom);
      end
      fifo_empty = (fifo_q.size() == 0);

      if (cyc == done_at) tx_done = 1'b1;
      else tx_done = spur_en && (done_at < cyc) && ($urandom_range(0, 7) == 0);
    end
  end

  // Monitor: derives expected handshakes from word-level rules and pops the scoreboards
  initial begin : monitor
    exp_t e;
    bit cur_busy, prev_idle, prev_nonempty;
    bit exp_rden, exp_txv, exp_wd;
    int bytes_sent, done_cyc, rden_cyc, last_idx;
    logic [7:0] last_a, last_b;
    forever begin
      @(negedge clk);
      if (!model_on) begin
        cur_busy = 1'b0; prev_idle = 1'b1; prev_nonempty = 1'b0;
        bytes_sent = 0; done_cyc = -100; rden_cyc = -100; last_idx = 0;
        last_a = '0; last_b = '0; done_at = -1;
        exp_a.delete();
        exp_b.delete();
        continue;
      end
      exp_rden = prev_idle && prev_nonempty;
      if (exp_rden) begin
        cur_busy   = 1'b1;
        rden_cyc   = cyc;
        bytes_sent = 0;
      end
      exp_txv = cur_busy && ((cyc == rden_cyc + LAT + 1) ||
                (bytes_sent > 0 && bytes_sent < WB && cyc == done_cyc + 2));
      exp_wd  = cur_busy && (bytes_sent == WB) && (cyc == done_cyc + 2);
      if (exp_txv && exp_a.size() > 0 && exp_b.size() > 0) begin
        e = exp_a.pop_front();
        last_a   = e.data;
        last_idx = e.idx;
        e = exp_b.pop_front();
        last_b   = e.data;
        bytes_sent++;
        done_at = cyc + ((uart_delay > 0) ? uart_delay : int'($urandom_range(1, 12)));
      end
      check("A rden", a_rden, exp_rden);
      check("A tx_valid", a_txv, exp_txv);
      check("A word_done", a_wd, exp_wd);
      check("A busy", a_busy, cur_busy);
      check("A tx_data", a_data, last_a);
      check("A byte_idx", a_idx, last_idx);
      check("B rden", b_rden, exp_rden);
      check("B tx_valid", b_txv, exp_txv);
      check("B word_done", b_wd, exp_wd);
      check("B busy", b_busy, cur_busy);
      check("B tx_data", b_data, last_b);
      check("B byte_idx", b_idx, last_idx);
      if (a_rden) n_rden++;
      if (a_txv) n_txv++;
      if (a_wd) n_wd++;
      if (cyc == done_at) done_cyc = cyc;
      prev_nonempty = !fifo_empty;
      prev_idle     = !cur_busy;
      if (exp_wd) cur_busy = 1'b0;
    end
  end

  initial begin : monitor_c
    forever begin
      @(negedge clk);
      if (c_txv) begin
        check("C byte pending", exp_c.size(), 1);
        if (exp_c.size() > 0) check("C tx_data", c_data, exp_c.pop_front());
        check("C byte_idx", c_idx, 0);
      end
    end
  end

  task automatic run_c(input logic [7:0] b);
    int k;
    bit seen;
    exp_c.push_back(b);
    c_fdata = b;
    c_empty = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(posedge clk); #2;
      seen = c_rden;
    end
    check("C rden seen", seen, 1);
    k = cyc;
    c_empty = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(posedge clk); #2;
      seen = c_txv;
    end
    check("C first tx_valid latency", cyc - k, 2);
    c_fdata = ~b;
    repeat (3) @(posedge clk);
    #2;
    c_tx_done = 1'b1;
    @(posedge clk); #2;
    c_tx_done = 1'b0;
    check("C word_done too early", c_wd, 0);
    @(posedge clk); #2;
    check("C word_done", c_wd, 1);
    check("C busy at word_done", c_busy, 1);
    @(posedge clk); #2;
    check("C busy after word_done", c_busy, 0);
  endtask

  initial begin : main
    bit done_ok;
    int snap_txv, snap_wd;
    rst = 1'b1;
    c_empty = 1'b1;
    c_fdata = '0;
    c_tx_done = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("reset A rden", a_rden, 0);
    check("reset A tx_valid", a_txv, 0);
    check("reset A busy", a_busy, 0);
    check("reset A tx_data", a_data, 0);
    check("reset C busy", c_busy, 0);

    rst        = 1'b0;
    model_on   = 1'b1;
    spur_en    = 1'b1;
    gen_target = NW;
    done_ok    = 1'b0;
    for (int i = 0; i < 20000 && !done_ok; i++) begin
      @(posedge clk); #3;
      done_ok = (pushed == NW) && (fifo_q.size() == 0) && (exp_a.size() == 0) && !a_busy;
    end
    repeat (5) @(posedge clk);
    #3;
    check("main phase drained", done_ok, 1);
    check("A rden count", n_rden, NW);
    check("A tx_valid count", n_txv, WB * NW);
    check("A word_done count", n_wd, NW);

    // Abort a word while the third byte is in flight
    uart_delay = 10;
    gen_target = NW + 1;
    done_ok    = 1'b0;
    for (int i = 0; i < 500 && !done_ok; i++) begin
      @(posedge clk); #3;
      done_ok = (pushed == NW + 1) && (exp_a.size() == 1) && a_busy;
    end
    check("reached third byte", done_ok, 1);
    model_on = 1'b0;
    rst      = 1'b1;
    #1;
    check("async reset A tx_valid", a_txv, 0);
    check("async reset A busy", a_busy, 0);
    check("async reset A tx_data", a_data, 0);
    check("async reset A byte_idx", a_idx, 0);
    check("async reset B tx_data", b_data, 0);
    check("async reset B busy", b_busy, 0);
    repeat (2) @(posedge clk);
    #2;
    rst      = 1'b0;
    model_on = 1'b1;
    snap_txv = n_txv;
    snap_wd  = n_wd;
    repeat (40) @(posedge clk);
    #3;
    check("tx_valid after reset", n_txv - snap_txv, 0);
    check("word_done after reset", n_wd - snap_wd, 0);

    // Byte-wide instance, with a stray tx_done while it is idle
    run_c(8'h55);
    c_tx_done = 1'b1;
    @(posedge clk); #2;
    c_tx_done = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("C idle after stray tx_done", c_busy, 0);
    run_c(8'hAA);
    repeat (3) @(posedge clk);
    #2;
    check("C bytes all sent", exp_c.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
